// File: rtl/dmem_rmw.sv
// Load/store front end: turns byte/half/word accesses into whole-word memory accesses
// (read-modify-write for sub-word stores). Optional: DMEM_MISALIGN_CHECK_EN.
module dmem_rmw #(
  parameter int unsigned WORD_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [2:0]          req_funct3,
  input  logic [WORD_LEN-1:0] req_addr,
  input  logic [WORD_LEN-1:0] req_wdata,
  output logic                resp_valid,
  output logic [WORD_LEN-1:0] resp_rdata,
  output logic                resp_err,
  output logic [WORD_LEN-1:0] mem_addr,
  output logic                mem_wen,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic [WORD_LEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StLd, StMrg} state_e;

  state_e              state_q, state_d;
  logic [1:0]          off_q, off_d;
  logic [2:0]          f3_q, f3_d;
  logic [WORD_LEN-1:0] wdata_q, wdata_d;
  logic [WORD_LEN-3:0] waddr_q, waddr_d;
  logic                resp_valid_d, resp_err_d;
  logic [WORD_LEN-1:0] resp_rdata_d;

  logic                accept, illegal, req_err;
  logic [1:0]          req_off;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [WORD_LEN-1:0] ld_data, mrg_data;

  assign accept = req_valid && req_ready;

  // Request decode: legality and the effective byte offset within the word.
  always_comb begin
    unique case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_wen;
      default:                illegal = 1'b1;
    endcase
    req_off = req_addr[1:0];
`ifdef DMEM_MISALIGN_CHECK_EN
    req_err = illegal
            || (req_funct3[1:0] == 2'b01 && req_addr[0])
            || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
    req_err = illegal;
    if (req_funct3[1:0] == 2'b01) req_off[0] = 1'b0;
    if (req_funct3[1:0] == 2'b10) req_off = 2'b00;
`endif
  end

  // Load extraction and store merge against the word returned by memory.
  always_comb begin
    ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata;
    endcase
    mrg_data = mem_rdata;
    if (f3_q[1:0] == 2'b00) mrg_data[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    else                    mrg_data[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      off_q      <= 2'b00;
      f3_q       <= 3'b000;
      wdata_q    <= '0;
      waddr_q    <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      f3_q       <= f3_d;
      wdata_q    <= wdata_d;
      waddr_q    <= waddr_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= resp_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    f3_d         = f3_q;
    wdata_d      = wdata_q;
    waddr_d      = waddr_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          off_d   = req_off;
          f3_d    = req_funct3;
          wdata_d = req_wdata;
          waddr_d = req_addr[WORD_LEN-1:2];
          if (req_err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (!req_wen) begin
            state_d = StLd;
          end else if (req_funct3[1:0] == 2'b10) begin
            resp_valid_d = 1'b1;
          end else begin
            state_d = StMrg;
          end
        end
      end
      StLd: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = ld_data;
        state_d      = StIdle;
      end
      StMrg: begin
        resp_valid_d = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = (state_q == StIdle) && !rst;
    mem_addr  = (state_q == StIdle) ? {req_addr[WORD_LEN-1:2], 2'b00} : {waddr_q, 2'b00};
    mem_wen   = 1'b0;
    mem_wdata = req_wdata;
    unique case (state_q)
      StIdle: mem_wen = accept && req_wen && !req_err && req_funct3[1:0] == 2'b10;
      StMrg: begin
        mem_wen   = !rst;
        mem_wdata = mrg_data;
      end
      default: mem_wen = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_dmem_rmw.sv
// Self-checking bench for dmem_rmw: directed table, multi-cycle corner sequences and a
// randomized run against a byte-level reference model.
module tb_dmem_rmw;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wen;

  always #5 clk = ~clk;

  dmem_rmw dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wen    (mem_wen),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Word memory with one-cycle registered read (read returns old data on a same-cycle write).
  logic [31:0] mem [0:255];
  int          wr_cnt = 0;
  always @(posedge clk) begin
    if (mem_wen) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    mem_rdata <= mem[mem_addr[9:2]];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Reference model: byte-granular view of memory.
  logic [31:0] ref_mem [0:255];

  task automatic ref_op(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic err,
                        output int lat, output int nw, output logic accw);
    int size, off, idx;
    logic ill, mis;
    logic [31:0] w, mask;
    size = 1 << f3[1:0];
    idx  = int'(addr[9:2]);
    ill  = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) || (wen && f3[2]);
    mis  = (int'(addr[1:0]) % size) != 0;
`ifdef DMEM_MISALIGN_CHECK_EN
    err = ill || mis;
`else
    err = ill;
`endif
    off  = (int'(addr[1:0]) / size) * size;
    rd   = 32'd0;
    nw   = 0;
    accw = 1'b0;
    if (err) begin
      lat = 1;
    end else if (wen) begin
      w = ref_mem[idx];
      for (int i = 0; i < size; i++) w[8*(off+i) +: 8] = wdata[8*i +: 8];
      ref_mem[idx] = w;
      nw   = 1;
      lat  = (size == 4) ? 1 : 2;
      accw = (size == 4);
    end else begin
      lat = 2;
      rd  = ref_mem[idx] >> (8 * off);
      if (size < 4) begin
        mask = (32'd1 << (8 * size)) - 32'd1;
        rd   = rd & mask;
        if (!f3[2] && rd[8*size-1]) rd = rd | ~mask;
      end
    end
  endtask

  task automatic do_req(input string nm, input logic wen, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                        input int exp_nw, input logic exp_accw);
    int   wr0, lat;
    logic got, er;
    logic [31:0] rd;
    @(negedge clk);
    req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    #1;
    check({nm, " req_ready"}, req_ready, 1);
    check({nm, " mem_wen@accept"}, mem_wen, exp_accw);
    wr0 = wr_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 1'b0; lat = 0; rd = 32'd0; er = 1'b0;
    for (int c = 1; c <= 4 && !got; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1; lat = c; rd = resp_rdata; er = resp_err;
      end
    end
    check({nm, " resp seen"}, got, 1);
    check({nm, " latency"}, lat, exp_lat);
    check({nm, " rdata"}, rd, exp_rd);
    check({nm, " err"}, er, exp_err);
    check({nm, " writes"}, wr_cnt - wr0, exp_nw);
  endtask

  task automatic run_ref(input string nm, input logic wen, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] rd;
    logic        err, accw;
    int          lat, nw;
    ref_op(wen, f3, addr, wdata, rd, err, lat, nw, accw);
    do_req(nm, wen, f3, addr, wdata, rd, err, lat, nw, accw);
  endtask

  typedef struct {
    string       nm;
    logic        wen;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] rd_m;
    logic        err_m, accw_m;
    int          lat_m, nw_m, wr0;

    for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;

    tbl.push_back('{"sw0 10",     1'b1, 3'd2, 32'h10, 32'h00000000, 32'h0, 1'b0});
    tbl.push_back('{"sw 10",      1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0});
    tbl.push_back('{"lw 10",      1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{"sw 20",      1'b1, 3'd2, 32'h20, 32'h11223344, 32'h0, 1'b0});
    tbl.push_back('{"sh 22",      1'b1, 3'd1, 32'h22, 32'hAAAA5566, 32'h0, 1'b0});
    tbl.push_back('{"lw 20a",     1'b0, 3'd2, 32'h20, 32'h0, 32'h55663344, 1'b0});
    tbl.push_back('{"sh 20",      1'b1, 3'd1, 32'h20, 32'h00007788, 32'h0, 1'b0});
    tbl.push_back('{"lw 20b",     1'b0, 3'd2, 32'h20, 32'h0, 32'h55667788, 1'b0});
    tbl.push_back('{"sw 30",      1'b1, 3'd2, 32'h30, 32'h80FF7F01, 32'h0, 1'b0});
    tbl.push_back('{"lb 31",      1'b0, 3'd0, 32'h31, 32'h0, 32'h0000007F, 1'b0});
    tbl.push_back('{"lb 32",      1'b0, 3'd0, 32'h32, 32'h0, 32'hFFFFFFFF, 1'b0});
    tbl.push_back('{"lbu 33",     1'b0, 3'd4, 32'h33, 32'h0, 32'h00000080, 1'b0});
    tbl.push_back('{"lh 32",      1'b0, 3'd1, 32'h32, 32'h0, 32'hFFFF80FF, 1'b0});
    tbl.push_back('{"lhu 32",     1'b0, 3'd5, 32'h32, 32'h0, 32'h000080FF, 1'b0});
    tbl.push_back('{"sw 40",      1'b1, 3'd2, 32'h40, 32'h0BADF00D, 32'h0, 1'b0});
`ifdef DMEM_MISALIGN_CHECK_EN
    tbl.push_back('{"lw 41 mis",  1'b0, 3'd2, 32'h41, 32'h0, 32'h0, 1'b1});
    tbl.push_back('{"lh 43 mis",  1'b0, 3'd1, 32'h43, 32'h0, 32'h0, 1'b1});
    tbl.push_back('{"sh 41 mis",  1'b1, 3'd1, 32'h41, 32'h00001234, 32'h0, 1'b1});
`else
    tbl.push_back('{"lw 41 mis",  1'b0, 3'd2, 32'h41, 32'h0, 32'h0BADF00D, 1'b0});
    tbl.push_back('{"lh 43 mis",  1'b0, 3'd1, 32'h43, 32'h0, 32'h00000BAD, 1'b0});
    tbl.push_back('{"sh 41 mis",  1'b1, 3'd1, 32'h41, 32'h00001234, 32'h0, 1'b0});
`endif
    tbl.push_back('{"ld f3=011",  1'b0, 3'd3, 32'h40, 32'h0, 32'h0, 1'b1});
    tbl.push_back('{"st f3=111",  1'b1, 3'd7, 32'h40, 32'hFFFFFFFF, 32'h0, 1'b1});
    tbl.push_back('{"st f3=100",  1'b1, 3'd4, 32'h40, 32'hFFFFFFFF, 32'h0, 1'b1});
    tbl.push_back('{"ld f3=110",  1'b0, 3'd6, 32'h40, 32'h0, 32'h0, 1'b1});
`ifdef DMEM_MISALIGN_CHECK_EN
    tbl.push_back('{"lw 40",      1'b0, 3'd2, 32'h40, 32'h0, 32'h0BADF00D, 1'b0});
`else
    tbl.push_back('{"lw 40",      1'b0, 3'd2, 32'h40, 32'h0, 32'h0BAD1234, 1'b0});
`endif
    tbl.push_back('{"lbu 42",     1'b0, 3'd4, 32'h42, 32'h0, 32'h000000AD, 1'b0});
    tbl.push_back('{"lb 42",      1'b0, 3'd0, 32'h42, 32'h0, 32'hFFFFFFAD, 1'b0});

    // Reset behaviour: write is suppressed and ready is low while rst is high.
    rst = 1'b1; req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h70; req_wdata = 32'h12345678;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst mem_wen", mem_wen, 0);
    check("rst req_ready", req_ready, 0);
    check("rst resp_valid", resp_valid, 0);
    check("rst resp_rdata", resp_rdata, 0);
    check("rst resp_err", resp_err, 0);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0; #1;
    check("post-rst req_ready", req_ready, 1);

    foreach (tbl[i]) begin
      ref_op(tbl[i].wen, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd_m, err_m, lat_m, nw_m, accw_m);
      do_req(tbl[i].nm, tbl[i].wen, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].err,
             lat_m, nw_m, accw_m);
    end

    // Back-to-back sb then lbu with req_valid held high throughout.
    run_ref("sw 50", 1'b1, 3'd2, 32'h50, 32'h12345678);
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'd0; req_addr = 32'h50;
    req_wdata = 32'h0000005A;
    #1 check("b2b sb ready", req_ready, 1);
    @(posedge clk);
    #1 req_wen = 1'b0; req_funct3 = 3'd4; req_wdata = 32'h0;
    @(negedge clk); #1;
    check("b2b MRG ready", req_ready, 0);
    check("b2b MRG mem_wen", mem_wen, 1);
    check("b2b MRG resp_valid", resp_valid, 0);
    @(negedge clk); #1;
    check("b2b sb resp_valid", resp_valid, 1);
    check("b2b sb resp_err", resp_err, 0);
    check("b2b lbu ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk); #1;
    check("b2b LD ready", req_ready, 0);
    check("b2b LD resp_valid", resp_valid, 0);
    @(negedge clk); #1;
    check("b2b lbu resp_valid", resp_valid, 1);
    check("b2b lbu rdata", resp_rdata, 32'h0000005A);
    ref_mem[32'h50 >> 2] = 32'h1234565A;

    // Reset during MRG drops the pending sub-word write and its response.
    run_ref("sw 60", 1'b1, 3'd2, 32'h60, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'd0; req_addr = 32'h61;
    req_wdata = 32'h00000011;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wr0 = wr_cnt;
    @(negedge clk);
    check("rstmrg ready", req_ready, 0);
    rst = 1'b1; #1;
    check("rstmrg mem_wen", mem_wen, 0);
    @(negedge clk);
    rst = 1'b0; #1;
    check("rstmrg resp_valid", resp_valid, 0);
    check("rstmrg ready after", req_ready, 1);
    @(negedge clk);
    check("rstmrg resp_valid2", resp_valid, 0);
    check("rstmrg writes", wr_cnt - wr0, 0);
    do_req("rstmrg lw 60", 1'b0, 3'd2, 32'h60, 32'h0, 32'hCAFEF00D, 1'b0, 2, 0, 1'b0);

    // Randomized traffic over a 16-word region.
    for (int i = 0; i < 16; i++) run_ref("rnd init", 1'b1, 3'd2, 32'h100 + 32'(4 * i), $urandom);
    for (int i = 0; i < 250; i++) begin
      logic [2:0] f3;
      f3 = 3'($urandom_range(0, 7));
      run_ref($sformatf("rnd %0d", i), 1'($urandom_range(0, 1)), f3,
              32'h100 + 32'($urandom_range(0, 63)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
